frag_align: RTL
===============

Name: frag_align

Overview:
Byte-lane aligner that sits directly upstream of the packet-merge stage. It pops variable-length fragments (1–8 bytes, LSB-justified) from a show-ahead input FIFO and rotates each fragment to the current running byte offset. It then writes 64-bit words with byte enables into the merge FIFO, asserting byte-enable bit 7 whenever a word's last lane is filled. Fragments that cross a word boundary are split across two output writes.

Parameters:
PAD_BYTE, 8'h00, fill value for pad lanes (used only with FRAG_ALIGN_PAD_EN)

Ports:
clk  in  1  clock
reset_l  in  1  reset, asynchronous, active-low
in_fifo_rd_data  in  64  fragment bytes; byte k in [8k+7:8k], lane 0 first
in_fifo_rd_cnt  in  4  valid byte count 0..8; values >8 treated as 8
in_fifo_rd_last  in  1  fragment ends a packet
in_fifo_ne  in  1  input FIFO not empty; head word valid (show-ahead)
in_fifo_re  out  1  combinational pop; consumes the head word this cycle
out_fifo_wr_data  out  64  rotated data
out_fifo_wr_be  out  8  byte enables
out_fifo_we  out  1  write strobe
out_fifo_full  in  1  merge FIFO full; asserted by the FIFO with ≥1 entry still free

Behaviour:
- Reset is asynchronous and active-low, on reset_l; clock is clk.
- Reset values: out_fifo_wr_data=0, out_fifo_wr_be=0, out_fifo_we=0, state=RUN, ofs=0, spill and last-pending registers cleared. in_fifo_re=0 while reset_l is low.
- Registered state: ofs[2:0] (next free lane), spill_data[63:0], spill_be[7:0], last_pend.
- States: RUN, SPILL, PAD.
- out_fifo_we defaults to 0 each cycle. Every write appears on the edge following the decision cycle (1-cycle latency).
- Lanes of out_fifo_wr_data not enabled by be are 0.
- in_fifo_re = (state==RUN) && in_fifo_ne && !out_fifo_full.
- RUN, on pop:
  - n = min(cnt,8).
  - rot = in data rotated left by ofs bytes.
  - mask16 = ((1<<n)-1) << ofs.
  - If mask16[7:0]!=0: write data=rot masked to lanes mask16[7:0], be=mask16[7:0].
  - If mask16[15:8]!=0: spill_be<=mask16[15:8], spill_data<=rot masked, last_pend<=last, go SPILL.
  - Else if last, FRAG_ALIGN_PAD_EN defined, and new ofs!=0: go PAD.
  - ofs <= (ofs+n) mod 8 (3-bit wrap).
  - n=0: fragment consumed, no write; last still honoured for PAD.
- SPILL: in_fifo_re=0. When !out_fifo_full: write spill_data/spill_be, then go PAD if last_pend && ofs!=0 && PAD enabled, else go RUN. When full: hold state.
- PAD: in_fifo_re=0. When !out_fifo_full: write be=8'hFF<<ofs, with lanes ofs..7=PAD_BYTE and all other lanes 0; ofs<=0; go RUN. When full: hold state.
- Any cycle with out_fifo_full high produces no write and no pop; all state is held.
- Throughput: 1 fragment/clock with no boundary crossing; 2 clocks for a crossing fragment.
- Reset mid-operation (e.g. in SPILL or PAD) discards pending spill/pad data and returns to RUN with ofs=0.

Optional Feature:
FRAG_ALIGN_PAD_EN
- Defined: at packet end (last=1), if the resulting ofs!=0, a PAD write completes the word up to lane 7 so the merge stage flushes it. Each packet then starts at lane 0.
- Undefined: the PAD state is never entered, last is ignored, and ofs carries across packet boundaries.

Test Plan:
1. Aligned stream: four fragments, cnt=8, ofs=0, data 0x0706050403020100+i → four writes, be=FF, data identical; ofs stays 0; in_fifo_re high on 4 consecutive cycles.
2. No crossing: cnt=3 bytes AA,BB,CC, then cnt=5 bytes 11,22,33,44,55 → write be=07 with lanes0-2=AA,BB,CC; then be=F8 with lanes3-7=11,22,33,44,55; final ofs=0.
3. Crossing: ofs=6, cnt=4 bytes 11,22,33,44 → write be=C0 with lanes6,7=11,22; next cycle write be=03 with lanes0,1=33,44 and in_fifo_re=0; ofs=2; RUN resumes on the third cycle.
4. Pad, with macro and PAD_BYTE=8'h00: ofs=0, cnt=3, last=1 → be=07, then be=F8 with lanes3-7=00, ofs=0. Without macro: single be=07 write, ofs=3.
5. Backpressure: hold out_fifo_full=1 for 5 cycles during SPILL while in_fifo_ne=1 → no we, no re, spill write emitted on the first cycle full drops.
6. Reset asserted in SPILL → we=0, be=0, ofs=0 immediately; after release, a cnt=8 fragment produces be=FF at lane 0.

Source files
------------

// File: rtl/frag_align.sv
// frag_align: rotates 1-8 byte fragments to the running lane offset and writes 64-bit words with byte enables.
// Define FRAG_ALIGN_PAD_EN to pad each packet's last word out to lane 7.
module frag_align #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [63:0] in_fifo_rd_data,
  input  logic [3:0]  in_fifo_rd_cnt,
  input  logic        in_fifo_rd_last,
  input  logic        in_fifo_ne,
  output logic        in_fifo_re,
  output logic [63:0] out_fifo_wr_data,
  output logic [7:0]  out_fifo_wr_be,
  output logic        out_fifo_we,
  input  logic        out_fifo_full
);
`ifdef FRAG_ALIGN_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif
  typedef enum logic [1:0] {RUN, SPILL, PAD} state_t;
  state_t      state_q, state_d;
  logic [2:0]  ofs_q, ofs_d, ofs_nxt;
  logic [63:0] spill_data_q, spill_data_d, wr_data_q, wr_data_d, rot;
  logic [7:0]  spill_be_q, spill_be_d, wr_be_q, wr_be_d, pad_be;
  logic        last_pend_q, last_pend_d, we_q, we_d;
  logic [3:0]  n;
  logic [15:0] mask16;
  logic [127:0] dbl;
  function automatic logic [63:0] lanes(input logic [7:0] be);
    for (int k = 0; k < 8; k++) lanes[8*k +: 8] = {8{be[k]}};
  endfunction
  assign n       = in_fifo_rd_cnt > 4'd8 ? 4'd8 : in_fifo_rd_cnt;
  assign mask16  = ((16'd1 << n) - 16'd1) << ofs_q;
  assign dbl     = {in_fifo_rd_data, in_fifo_rd_data} << {ofs_q, 3'b000};
  assign rot     = dbl[127:64];
  assign ofs_nxt = ofs_q + n[2:0];
  assign pad_be  = 8'hFF << ofs_q;
  assign in_fifo_re = reset_l && state_q == RUN && in_fifo_ne && !out_fifo_full;
  assign out_fifo_wr_data = wr_data_q;
  assign out_fifo_wr_be   = wr_be_q;
  assign out_fifo_we      = we_q;
  always_comb begin
    state_d      = state_q;
    ofs_d        = ofs_q;
    spill_data_d = spill_data_q;
    spill_be_d   = spill_be_q;
    last_pend_d  = last_pend_q;
    wr_data_d    = wr_data_q;
    wr_be_d      = wr_be_q;
    we_d         = 1'b0;
    if (in_fifo_re) begin
      we_d  = |mask16[7:0];
      ofs_d = ofs_nxt;
      if (|mask16[7:0]) begin
        wr_data_d = rot & lanes(mask16[7:0]);
        wr_be_d   = mask16[7:0];
      end
      if (|mask16[15:8]) begin
        spill_be_d   = mask16[15:8];
        spill_data_d = rot & lanes(mask16[15:8]);
        last_pend_d  = in_fifo_rd_last;
        state_d      = SPILL;
      end else if (PadEn && in_fifo_rd_last && ofs_nxt != 3'd0) state_d = PAD;
    end else if (!out_fifo_full && state_q == SPILL) begin
      we_d      = 1'b1;
      wr_data_d = spill_data_q;
      wr_be_d   = spill_be_q;
      state_d   = (PadEn && last_pend_q && ofs_q != 3'd0) ? PAD : RUN;
    end else if (!out_fifo_full && state_q == PAD) begin
      we_d      = 1'b1;
      wr_data_d = lanes(pad_be) & {8{PAD_BYTE}};
      wr_be_d   = pad_be;
      ofs_d     = 3'd0;
      state_d   = RUN;
    end
  end
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= RUN;
      ofs_q        <= 3'd0;
      spill_data_q <= 64'd0;
      spill_be_q   <= 8'd0;
      last_pend_q  <= 1'b0;
      wr_data_q    <= 64'd0;
      wr_be_q      <= 8'd0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ofs_q        <= ofs_d;
      spill_data_q <= spill_data_d;
      spill_be_q   <= spill_be_d;
      last_pend_q  <= last_pend_d;
      wr_data_q    <= wr_data_d;
      wr_be_q      <= wr_be_d;
      we_q         <= we_d;
    end
  end
endmodule
